// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard/stall controller for a 5-stage in-order pipeline
// whose conditional branches compare their operands in ID.
//
// Ports
//   clk, rst_n                        clock, synchronous active-low reset
//   if_id_rs1/rs2, if_id_use_rs1/rs2  decode-stage source registers and use flags
//   if_id_branch, branch_taken        decode-stage branch and its ID resolution
//   id_ex_rd/reg_write/mem_read       EX-stage destination info
//   ex_mem_rd/reg_write/mem_read      MEM-stage destination info
//   mem_wb_rd/reg_write               WB-stage destination info
//   mem_busy                          data memory not ready, freezes the front end
//   pc_write, if_id_write             PC and IF/ID register enables
//   if_id_flush                       load a NOP into IF/ID on the next edge
//   id_ex_bubble                      squash control bits entering ID/EX
//   rs1_sel, rs2_sel                  branch comparator operand source
//                                     (00 regfile, 01 EX/MEM ALU, 10 MEM/WB)
//   stall_cycles                      saturating count of cycles with pc_write=0
module pipe_stall_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  if_id_rs1,
    input  logic [4:0]  if_id_rs2,
    input  logic        if_id_use_rs1,
    input  logic        if_id_use_rs2,
    input  logic        if_id_branch,
    input  logic        branch_taken,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_reg_write,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  ex_mem_rd,
    input  logic        ex_mem_reg_write,
    input  logic        ex_mem_mem_read,
    input  logic [4:0]  mem_wb_rd,
    input  logic        mem_wb_reg_write,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic [1:0]  rs1_sel,
    output logic [1:0]  rs2_sel,
    output logic [15:0] stall_cycles
);

    typedef enum logic [0:0] {StRun, StHold} state_e;

    state_e      state_q, state_d;
    logic [15:0] stall_cycles_q;

    // x0 is hard-wired zero, so it never creates a dependency.
    function automatic logic match(input logic use_x, input logic [4:0] rs,
                                   input logic [4:0] rd);
        return use_x && (rd != 5'd0) && (rs == rd);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_x, input logic [4:0] rs,
                                           input logic ex_mem_alu_wr,
                                           input logic [4:0] ex_mem_dst,
                                           input logic mem_wb_wr,
                                           input logic [4:0] mem_wb_dst);
        if (ex_mem_alu_wr && match(use_x, rs, ex_mem_dst)) begin
            return 2'b01;
        end else if (mem_wb_wr && match(use_x, rs, mem_wb_dst)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    logic match_ex_rd;
    logic match_mem_rd;
    logic h_lu;
    logic h_ba;
    logic h_bl;
    logic hazard;
    logic ex_mem_alu_wr;

    always_comb begin
        match_ex_rd   = match(if_id_use_rs1, if_id_rs1, id_ex_rd) ||
                        match(if_id_use_rs2, if_id_rs2, id_ex_rd);
        match_mem_rd  = match(if_id_use_rs1, if_id_rs1, ex_mem_rd) ||
                        match(if_id_use_rs2, if_id_rs2, ex_mem_rd);
        h_lu          = id_ex_mem_read && match_ex_rd;
        // ALU result is not ready until end of EX, but the branch needs it in ID.
        h_ba          = if_id_branch && id_ex_reg_write && !id_ex_mem_read && match_ex_rd;
        // Load data is only available from MEM/WB, one cycle too late for ID.
        h_bl          = if_id_branch && ex_mem_mem_read && match_mem_rd;
        hazard        = h_lu || h_ba || h_bl;
        ex_mem_alu_wr = ex_mem_reg_write && !ex_mem_mem_read;
    end

    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        rs1_sel      = 2'b00;
        rs2_sel      = 2'b00;

        if (!rst_n) begin
            state_d      = StRun;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            // Whole front end frozen; ID/EX is held too, so no bubble is inserted.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else begin
            unique case (state_q)
                StHold: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = StRun;
                end
                StRun: begin
                    if (hazard) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        // Load feeding a branch: one cycle for EX->MEM, one more for MEM->WB.
                        if (if_id_branch && h_lu) begin
                            state_d = StHold;
                        end
                    end else begin
                        rs1_sel     = fwd_sel(if_id_use_rs1, if_id_rs1, ex_mem_alu_wr,
                                              ex_mem_rd, mem_wb_reg_write, mem_wb_rd);
                        rs2_sel     = fwd_sel(if_id_use_rs2, if_id_rs2, ex_mem_alu_wr,
                                              ex_mem_rd, mem_wb_reg_write, mem_wb_rd);
                        if_id_flush = if_id_branch && branch_taken;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StRun;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (!pc_write && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  if_id_rs1, if_id_rs2;
    logic        if_id_use_rs1, if_id_use_rs2;
    logic        if_id_branch, branch_taken;
    logic [4:0]  id_ex_rd;
    logic        id_ex_reg_write, id_ex_mem_read;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_reg_write, ex_mem_mem_read;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_reg_write;
    logic        mem_busy;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [1:0]  rs1_sel, rs2_sel;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_id_rs1        (if_id_rs1),
        .if_id_rs2        (if_id_rs2),
        .if_id_use_rs1    (if_id_use_rs1),
        .if_id_use_rs2    (if_id_use_rs2),
        .if_id_branch     (if_id_branch),
        .branch_taken     (branch_taken),
        .id_ex_rd         (id_ex_rd),
        .id_ex_reg_write  (id_ex_reg_write),
        .id_ex_mem_read   (id_ex_mem_read),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .ex_mem_mem_read  (ex_mem_mem_read),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_reg_write (mem_wb_reg_write),
        .mem_busy         (mem_busy),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_bubble     (id_ex_bubble),
        .rs1_sel          (rs1_sel),
        .rs2_sel          (rs2_sel),
        .stall_cycles     (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pc_write, if_id_write, if_id_flush, id_ex_bubble in one go.
    task automatic check_ctrl(input string tag, input logic [3:0] exp);
        check({tag, ".pc_write"},     {31'd0, pc_write},     {31'd0, exp[3]});
        check({tag, ".if_id_write"},  {31'd0, if_id_write},  {31'd0, exp[2]});
        check({tag, ".if_id_flush"},  {31'd0, if_id_flush},  {31'd0, exp[1]});
        check({tag, ".id_ex_bubble"}, {31'd0, id_ex_bubble}, {31'd0, exp[0]});
    endtask

    task automatic check_sel(input string tag, input logic [1:0] e1, input logic [1:0] e2);
        check({tag, ".rs1_sel"}, {30'd0, rs1_sel}, {30'd0, e1});
        check({tag, ".rs2_sel"}, {30'd0, rs2_sel}, {30'd0, e2});
    endtask

    task automatic check_cnt(input string tag, input int exp);
        check({tag, ".stall_cycles"}, {16'd0, stall_cycles}, exp);
    endtask

    task automatic clear_inputs();
        if_id_rs1 = '0; if_id_rs2 = '0; if_id_use_rs1 = 0; if_id_use_rs2 = 0;
        if_id_branch = 0; branch_taken = 0;
        id_ex_rd = '0; id_ex_reg_write = 0; id_ex_mem_read = 0;
        ex_mem_rd = '0; ex_mem_reg_write = 0; ex_mem_mem_read = 0;
        mem_wb_rd = '0; mem_wb_reg_write = 0; mem_busy = 0;
    endtask

    // Advance one clock; inputs are then changed 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Decode holds a branch on rs1=7 while a load to x7 sits in EX.
    task automatic load_then_branch();
        clear_inputs();
        if_id_branch = 1; if_id_use_rs1 = 1; if_id_rs1 = 5'd7;
        id_ex_mem_read = 1; id_ex_reg_write = 1; id_ex_rd = 5'd7;
    endtask

    // Control vectors: {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    localparam logic [3:0] Run   = 4'b1100;
    localparam logic [3:0] Stall = 4'b0001;
    localparam logic [3:0] Frz   = 4'b0000;
    localparam logic [3:0] Flush = 4'b1110;
    localparam logic [3:0] Rst   = 4'b0001;

    initial begin
        clear_inputs();
        rst_n = 0;

        // Reset state
        #3;
        check_ctrl("rst_out", Rst);
        check_sel("rst_out", 2'b00, 2'b00);
        step();
        step();
        check_cnt("rst", 0);
        check_ctrl("rst_hold", Rst);
        rst_n = 1;
        #1;
        check_ctrl("idle", Run);
        check_sel("idle", 2'b00, 2'b00);

        // Load-use on rs2, no branch
        id_ex_mem_read = 1; id_ex_rd = 5'd5; if_id_use_rs2 = 1; if_id_rs2 = 5'd5;
        #1;
        check_ctrl("lu", Stall);
        check_sel("lu", 2'b00, 2'b00);
        step();
        check_cnt("lu", 1);
        clear_inputs();
        if_id_use_rs2 = 1; if_id_rs2 = 5'd5;
        ex_mem_mem_read = 1; ex_mem_reg_write = 1; ex_mem_rd = 5'd5;
        #1;
        check_ctrl("lu_after", Run);
        check_sel("lu_after", 2'b00, 2'b00);
        step();
        check_cnt("lu_after", 1);

        // x0 never creates a hazard
        clear_inputs();
        id_ex_mem_read = 1; id_ex_rd = 5'd0; if_id_use_rs1 = 1; if_id_rs1 = 5'd0;
        #1;
        check_ctrl("x0", Run);
        step();
        check_cnt("x0", 1);

        // ALU result feeding a branch: one stall then EX/MEM forward
        clear_inputs();
        if_id_branch = 1; if_id_use_rs2 = 1; if_id_rs2 = 5'd3;
        id_ex_reg_write = 1; id_ex_rd = 5'd3;
        #1;
        check_ctrl("alu_br", Stall);
        check_sel("alu_br", 2'b00, 2'b00);
        step();
        check_cnt("alu_br", 2);
        id_ex_reg_write = 0; id_ex_rd = '0;
        ex_mem_reg_write = 1; ex_mem_rd = 5'd3;
        #1;
        check_ctrl("alu_br_fwd", Run);
        check_sel("alu_br_fwd", 2'b00, 2'b01);
        step();
        check_cnt("alu_br_fwd", 2);

        // Load feeding a branch: two stalls then MEM/WB forward
        load_then_branch();
        #1;
        check_ctrl("ltb_1", Stall);
        step();
        check_cnt("ltb_1", 3);
        id_ex_mem_read = 0; id_ex_reg_write = 0; id_ex_rd = '0;
        ex_mem_mem_read = 1; ex_mem_reg_write = 1; ex_mem_rd = 5'd7;
        #1;
        check_ctrl("ltb_2", Stall);
        check_sel("ltb_2", 2'b00, 2'b00);
        step();
        check_cnt("ltb_2", 4);
        ex_mem_mem_read = 0; ex_mem_reg_write = 0; ex_mem_rd = '0;
        mem_wb_reg_write = 1; mem_wb_rd = 5'd7;
        #1;
        check_ctrl("ltb_3", Run);
        check_sel("ltb_3", 2'b10, 2'b00);
        step();
        check_cnt("ltb_3", 4);

        // Lone load-in-MEM hazard stalls once without entering HOLD
        clear_inputs();
        if_id_branch = 1; if_id_use_rs2 = 1; if_id_rs2 = 5'd9;
        ex_mem_mem_read = 1; ex_mem_reg_write = 1; ex_mem_rd = 5'd9;
        #1;
        check_ctrl("bl", Stall);
        step();
        clear_inputs();
        #1;
        check_ctrl("bl_after", Run);
        step();
        check_cnt("bl_after", 5);

        // Taken branch frozen by mem_busy, then flushes exactly once
        clear_inputs();
        if_id_branch = 1; branch_taken = 1; mem_busy = 1;
        #1;
        check_ctrl("busy_br", Frz);
        step();
        check_cnt("busy_br", 6);
        mem_busy = 0;
        #1;
        check_ctrl("br_flush", Flush);
        step();
        check_cnt("br_flush", 6);
        clear_inputs();
        #1;
        check_ctrl("br_after", Run);

        // mem_busy holds HOLD; the second stall still follows
        step();
        load_then_branch();
        #1;
        check_ctrl("hold_busy_a", Stall);
        step();
        clear_inputs();
        mem_busy = 1;
        #1;
        check_ctrl("hold_busy", Frz);
        step();
        mem_busy = 0;
        #1;
        check_ctrl("hold_resume", Stall);
        step();
        check_cnt("hold_resume", 9);
        #1;
        check_ctrl("hold_done", Run);

        // Reset asserted while in HOLD
        step();
        load_then_branch();
        #1;
        check_ctrl("rst_hold_a", Stall);
        step();
        check_cnt("rst_hold_a", 10);
        clear_inputs();
        rst_n = 0;
        #1;
        check_ctrl("rst_in_hold", Rst);
        check_sel("rst_in_hold", 2'b00, 2'b00);
        step();
        check_cnt("rst_in_hold", 0);
        rst_n = 1;
        #1;
        check_ctrl("rst_release", Run);
        step();
        check_cnt("rst_release", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
